// File: rtl/stream_hsmooth_pkg.sv
// Shared types and constants for the horizontal smoothing stream stage.
// Imported by the top level and by the 3-tap filter sub-module.
package stream_hsmooth_pkg;

    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int NUM_CH = PIX_W / CH_W;

    localparam logic [3:0] VIDEO_PKT_ID = 4'h0;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PASS  = 2'd1,
        VID   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // A header only opens a filtered video packet when its type nibble says video and the filter is on.
    function automatic logic is_video_hdr(input logic [3:0] pkt_id, input logic en);
        return (pkt_id == VIDEO_PKT_ID) && en;
    endfunction

endpackage

// File: rtl/hsmooth_tap3.sv
// Combinational [1 2 1]/4 filter applied independently to each 8-bit colour channel.
// A 10-bit intermediate holds the worst case 255+510+255+2, so no saturation is required.
module hsmooth_tap3
    import stream_hsmooth_pkg::*;
(
    input  logic [PIX_W-1:0] i_a,
    input  logic [PIX_W-1:0] i_b,
    input  logic [PIX_W-1:0] i_c,
    output logic [PIX_W-1:0] o_y
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CH_W+1:0] w_sum;

        assign w_sum = (CH_W+2)'(i_a[ch*CH_W +: CH_W])
                     + ((CH_W+2)'(i_b[ch*CH_W +: CH_W]) << 1)
                     + (CH_W+2)'(i_c[ch*CH_W +: CH_W])
                     + (CH_W+2)'(2);

        assign o_y[ch*CH_W +: CH_W] = CH_W'(w_sum >> 2);
    end

endmodule

// File: rtl/stream_hsmooth.sv
// Avalon-ST stage that smooths video rows horizontally with a [1 2 1]/4 kernel per channel.
// Headers and non-video packets pass through unchanged; one output beat per input pixel.
module stream_hsmooth
    import stream_hsmooth_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PIX_W-1:0]   sink_data,
    input  logic               sink_valid,
    output logic               sink_ready,
    input  logic               sink_sop,
    input  logic               sink_eop,
    output logic [PIX_W-1:0]   source_data,
    output logic               source_valid,
    input  logic               source_ready,
    output logic               source_sop,
    output logic               source_eop,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int            X_W      = $clog2(IMAGE_W);
    localparam logic [X_W-1:0] LAST_COL = X_W'(IMAGE_W - 1);

    state_t             r_state;
    state_t             w_state_next;
    state_t             w_hdr_next;

    logic [PIX_W-1:0]   r_prev;
    logic [PIX_W-1:0]   r_cur;
    logic [X_W-1:0]     r_x;
    logic               r_last_eop;
    logic [COUNT_W-1:0] r_frame_count;

    logic [PIX_W-1:0]   r_src_data;
    logic               r_src_valid;
    logic               r_src_sop;
    logic               r_src_eop;

    logic               w_load;
    logic               w_acc;
    logic               w_last_col;
    logic [PIX_W-1:0]   w_tap_c;
    logic [PIX_W-1:0]   w_filt;

    logic               w_emit;
    logic [PIX_W-1:0]   w_out_data;
    logic               w_out_sop;
    logic               w_out_eop;
    logic               w_pix_acc;
    logic               w_flush_fire;

    assign w_load     = ~r_src_valid | source_ready;
    assign sink_ready = ~reset & w_load & (r_state != FLUSH);
    assign w_acc      = sink_valid & sink_ready;
    assign w_last_col = (r_x == LAST_COL);

    // In FLUSH the right neighbour of the final column is the column itself.
    assign w_tap_c = (r_state == FLUSH) ? r_cur : sink_data;

    hsmooth_tap3 u_tap3 (
        .i_a (r_prev),
        .i_b (r_cur),
        .i_c (w_tap_c),
        .o_y (w_filt)
    );

    // Any accepted sop is a header, whatever state we were in.
    always_comb begin
        w_hdr_next = PASS;
        if (sink_eop) begin
            w_hdr_next = HDR;
        end else if (is_video_hdr(sink_data[3:0], enable)) begin
            w_hdr_next = VID;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR: begin
                if (w_acc && sink_sop) begin
                    w_state_next = w_hdr_next;
                end
            end
            PASS: begin
                if (w_acc) begin
                    if (sink_sop) begin
                        w_state_next = w_hdr_next;
                    end else if (sink_eop) begin
                        w_state_next = HDR;
                    end
                end
            end
            VID: begin
                if (w_acc) begin
                    if (sink_sop) begin
                        w_state_next = w_hdr_next;
                    end else if (w_last_col || sink_eop) begin
                        w_state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_load) begin
                    w_state_next = r_last_eop ? HDR : VID;
                end
            end
            default: w_state_next = HDR;
        endcase
    end

    // The first pixel of a row only primes the holding registers; later pixels emit column x-1.
    always_comb begin
        w_emit       = 1'b0;
        w_out_data   = sink_data;
        w_out_sop    = sink_sop;
        w_out_eop    = sink_eop;
        w_pix_acc    = 1'b0;
        w_flush_fire = 1'b0;
        case (r_state)
            HDR, PASS: begin
                w_emit = w_acc;
            end
            VID: begin
                if (w_acc) begin
                    if (sink_sop) begin
                        w_emit = 1'b1;
                    end else begin
                        w_pix_acc = 1'b1;
                        if (r_x != '0) begin
                            w_emit     = 1'b1;
                            w_out_data = w_filt;
                            w_out_sop  = 1'b0;
                            w_out_eop  = 1'b0;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_load) begin
                    w_flush_fire = 1'b1;
                    w_emit       = 1'b1;
                    w_out_data   = w_filt;
                    w_out_sop    = 1'b0;
                    w_out_eop    = r_last_eop;
                end
            end
            default: ;
        endcase
    end

    // Single-entry output register; contents are frozen while a beat waits on a stalled sink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_valid <= 1'b0;
            r_src_data  <= '0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end else if (w_load) begin
            r_src_valid <= w_emit;
            if (w_emit) begin
                r_src_data <= w_out_data;
                r_src_sop  <= w_out_sop;
                r_src_eop  <= w_out_eop;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= '0;
            r_cur      <= '0;
            r_x        <= '0;
            r_last_eop <= 1'b0;
        end else begin
            if (w_acc && sink_sop) begin
                r_x <= '0;
            end
            if (w_pix_acc) begin
                r_cur  <= sink_data;
                r_prev <= (r_x == '0) ? sink_data : r_cur;
                r_x    <= r_x + 1'b1;
                if (w_last_col || sink_eop) begin
                    r_last_eop <= sink_eop;
                end
            end
            if (w_flush_fire) begin
                r_x <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_flush_fire && r_last_eop) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign source_data  = r_src_data;
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_sop;
    assign source_eop   = r_src_eop;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_stream_hsmooth.sv
// Bench for stream_hsmooth with IMAGE_W=4: directed vector tables, a mid-row reset,
// and randomized packets checked against a packet-level smoothing model.
module tb_stream_hsmooth;

    localparam int W = 4;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        logic        en;
        logic        endsRow;
    } beat_t;

    typedef struct {
        int          grp;
        logic        hasIn;
        logic        en;
        logic [23:0] inData;
        logic        inSop;
        logic        inEop;
        logic        hasExp;
        logic [23:0] expData;
        logic        expSop;
        logic        expEop;
        int          fcInc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [23:0] sink_data;
    logic        sink_valid;
    logic        sink_ready;
    logic        sink_sop;
    logic        sink_eop;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] frame_count;

    int          errors = 0;
    int          checks = 0;
    int          readyMode = 0;
    logic [15:0] expFc = '0;

    vec_t        vecs[$];
    beat_t       txQ[$];
    beat_t       expQ[$];
    beat_t       rxQ[$];

    logic        prevStall = 1'b0;
    logic [23:0] prevData;
    logic        prevSop;
    logic        prevEop;

    stream_hsmooth #(.IMAGE_W(W), .COUNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .frame_count  (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Downstream ready: 0 = always, 1 = repeating 1,0,0 pattern, 2 = random.
    initial begin
        int cyc;
        cyc = 0;
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (readyMode)
                0: source_ready = 1'b1;
                1: source_ready = ((cyc % 3) == 0);
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beats that transfer on the coming edge are recorded mid-cycle; stalled beats must hold still.
    always @(negedge clk) begin
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checks++;
                if (!source_valid || source_data !== prevData ||
                    source_sop !== prevSop || source_eop !== prevEop) begin
                    errors++;
                    $display("[TB] FAIL stallHold: got valid=%b data=%h sop=%b eop=%b want valid=1 data=%h sop=%b eop=%b",
                             source_valid, source_data, source_sop, source_eop, prevData, prevSop, prevEop);
                end
            end
            if (source_valid && source_ready) begin
                beat_t b;
                b.data = source_data;
                b.sop = source_sop;
                b.eop = source_eop;
                b.en = 1'b0;
                b.endsRow = 1'b0;
                rxQ.push_back(b);
            end
            prevStall = source_valid & ~source_ready;
            prevData  = source_data;
            prevSop   = source_sop;
            prevEop   = source_eop;
        end
    end

    function automatic logic [23:0] rPix(input int r);
        logic [7:0] v;
        v = 8'(r);
        return {v, 16'h0000};
    endfunction

    function automatic logic [23:0] smooth(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        logic [23:0] y;
        int s;
        y = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(a[ch*8 +: 8]) + 2 * int'(b[ch*8 +: 8]) + int'(c[ch*8 +: 8]) + 2;
            y[ch*8 +: 8] = 8'(s / 4);
        end
        return y;
    endfunction

    task automatic addVec(input int g, input logic hi, input logic en, input logic [23:0] id,
                          input logic is, input logic ie, input logic he, input logic [23:0] ed,
                          input logic es, input logic ee, input int fc);
        vec_t v;
        v.grp = g; v.hasIn = hi; v.en = en; v.inData = id; v.inSop = is; v.inEop = ie;
        v.hasExp = he; v.expData = ed; v.expSop = es; v.expEop = ee; v.fcInc = fc;
        vecs.push_back(v);
    endtask

    task automatic addSame(input int g, input logic en, input logic [23:0] d, input logic sop, input logic eop);
        addVec(g, 1'b1, en, d, sop, eop, 1'b1, d, sop, eop, 0);
    endtask

    task automatic addPix(input int g, input int inR, input int expR, input logic eop, input int fc);
        addVec(g, 1'b1, 1'b1, rPix(inR), 1'b0, eop, 1'b1, rPix(expR), 1'b0, eop, fc);
    endtask

    task automatic pushTx(input logic [23:0] d, input logic sop, input logic eop, input logic en);
        beat_t b;
        b.data = d; b.sop = sop; b.eop = eop; b.en = en; b.endsRow = 1'b0;
        txQ.push_back(b);
    endtask

    task automatic pushExp(input logic [23:0] d, input logic sop, input logic eop);
        beat_t b;
        b.data = d; b.sop = sop; b.eop = eop; b.en = 1'b0; b.endsRow = 1'b0;
        expQ.push_back(b);
    endtask

    // Flag beats that close a video row, after which the stage must stop accepting for a cycle.
    task automatic markRows();
        logic inVid;
        int x;
        inVid = 1'b0;
        x = 0;
        for (int i = 0; i < txQ.size(); i++) begin
            txQ[i].endsRow = 1'b0;
            if (txQ[i].sop) begin
                inVid = (txQ[i].data[3:0] == 4'h0) && txQ[i].en && !txQ[i].eop;
                x = 0;
            end else if (inVid) begin
                txQ[i].endsRow = (x == W - 1) || txQ[i].eop;
                x = txQ[i].endsRow ? 0 : x + 1;
                if (txQ[i].eop) inVid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int gapPct);
        int idx;
        int cyc;
        logic acc;
        logic flushChk;
        idx = 0;
        cyc = 0;
        flushChk = 1'b0;
        sink_valid = 1'b0;
        while (idx < txQ.size() && cyc < 4000) begin
            if (!sink_valid && ($urandom_range(0, 99) >= gapPct)) begin
                sink_valid = 1'b1;
                sink_data  = txQ[idx].data;
                sink_sop   = txQ[idx].sop;
                sink_eop   = txQ[idx].eop;
                enable     = txQ[idx].en;
            end
            @(negedge clk);
            if (flushChk) begin
                checks++;
                if (sink_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL flushReady: got sink_ready=%b want 0", sink_ready);
                end
                flushChk = 1'b0;
            end
            acc = sink_valid & sink_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                flushChk = txQ[idx].endsRow;
                idx++;
                sink_valid = 1'b0;
            end
        end
        sink_valid = 1'b0;
        if (flushChk) begin
            @(negedge clk);
            checks++;
            if (sink_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flushReady: got sink_ready=%b want 0", sink_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (idx < txQ.size()) begin
            errors++;
            $display("[TB] FAIL sinkTimeout: got %0d beats accepted want %0d", idx, txQ.size());
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (rxQ.size() < expQ.size() && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d beats want %0d", rxQ.size(), expQ.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        int n;
        checks++;
        if (rxQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL %s.count: got %0d beats want %0d", name, rxQ.size(), expQ.size());
        end
        n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rxQ[i].data !== expQ[i].data || rxQ[i].sop !== expQ[i].sop || rxQ[i].eop !== expQ[i].eop) begin
                errors++;
                $display("[TB] FAIL %s.beat%0d: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                         name, i, rxQ[i].data, rxQ[i].sop, rxQ[i].eop, expQ[i].data, expQ[i].sop, expQ[i].eop);
            end
        end
        checks++;
        if (frame_count !== expFc) begin
            errors++;
            $display("[TB] FAIL %s.frameCount: got %0d want %0d", name, frame_count, expFc);
        end
        txQ.delete();
        expQ.delete();
        rxQ.delete();
    endtask

    task automatic runGroup(input int g, input int rMode, input int gapPct, input string name);
        readyMode = rMode;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].grp == g) begin
                if (vecs[i].hasIn) pushTx(vecs[i].inData, vecs[i].inSop, vecs[i].inEop, vecs[i].en);
                if (vecs[i].hasExp) pushExp(vecs[i].expData, vecs[i].expSop, vecs[i].expEop);
                expFc = expFc + 16'(vecs[i].fcInc);
            end
        end
        markRows();
        applyStimulus(gapPct);
        waitDrain();
        checkOutput(name);
    endtask

    // Reference: every row is smoothed with its own end pixels replicated; bypassed packets are copied.
    task automatic genPacket();
        int kind;
        int n;
        int s;
        int L;
        logic en;
        logic [23:0] rnd;
        logic [23:0] hdr;
        logic [23:0] px[$];
        kind = $urandom_range(0, 4);
        rnd  = 24'($urandom());
        en   = (kind == 2) ? 1'b0 : 1'b1;
        case (kind)
            0, 1, 2: hdr = {rnd[23:4], 4'h0};
            3:       hdr = {rnd[23:4], 4'($urandom_range(1, 15))};
            default: begin
                hdr = rnd;
                en  = 1'($urandom_range(0, 1));
            end
        endcase
        pushTx(hdr, 1'b1, kind == 4, en);
        pushExp(hdr, 1'b1, kind == 4);
        if (kind == 4) return;
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) begin
            px.push_back(24'($urandom()));
            pushTx(px[i], 1'b0, i == n - 1, en);
        end
        if (kind <= 1) begin
            s = 0;
            while (s < n) begin
                L = (n - s < W) ? n - s : W;
                for (int j = 0; j < L; j++) begin
                    pushExp(smooth(px[s + ((j == 0) ? j : j - 1)], px[s + j],
                                   px[s + ((j == L - 1) ? j : j + 1)]), 1'b0, (s + j) == n - 1);
                end
                s += L;
            end
            expFc = expFc + 16'd1;
        end else begin
            for (int i = 0; i < n; i++) pushExp(px[i], 1'b0, i == n - 1);
        end
    endtask

    initial begin
        // Group 1: basic video frame, R ramp 0,4,8,12.
        addSame(1, 1'b1, 24'h000000, 1'b1, 1'b0);
        addPix(1, 0, 1, 1'b0, 0);
        addPix(1, 4, 4, 1'b0, 0);
        addPix(1, 8, 8, 1'b0, 0);
        addPix(1, 12, 11, 1'b1, 1);
        // Group 2: non-video packet passes through.
        addSame(2, 1'b1, 24'h00000F, 1'b1, 1'b0);
        addSame(2, 1'b1, 24'hABCDEF, 1'b0, 1'b0);
        addSame(2, 1'b1, 24'h123456, 1'b0, 1'b0);
        addSame(2, 1'b1, 24'h00FF00, 1'b0, 1'b1);
        // Group 3: filter disabled at sop.
        addSame(3, 1'b0, 24'h000000, 1'b1, 1'b0);
        addSame(3, 1'b0, rPix(0), 1'b0, 1'b0);
        addSame(3, 1'b0, rPix(4), 1'b0, 1'b0);
        addSame(3, 1'b0, rPix(8), 1'b0, 1'b0);
        addSame(3, 1'b0, rPix(12), 1'b0, 1'b1);
        // Group 4: short row terminated by eop.
        addSame(4, 1'b1, 24'h000000, 1'b1, 1'b0);
        addPix(4, 40, 50, 1'b0, 0);
        addPix(4, 80, 80, 1'b0, 0);
        addPix(4, 120, 110, 1'b1, 1);
        // Group 5: eop on the very first pixel.
        addSame(5, 1'b1, 24'h000000, 1'b1, 1'b0);
        addVec(5, 1'b1, 1'b1, 24'h6407C8, 1'b0, 1'b1, 1'b1, 24'h6407C8, 1'b0, 1'b1, 1);
        // Group 6: sop inside a video row drops the partial row.
        addSame(6, 1'b1, 24'h000000, 1'b1, 1'b0);
        addPix(6, 40, 50, 1'b0, 0);
        addVec(6, 1'b1, 1'b1, rPix(80), 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 0);
        addSame(6, 1'b1, 24'h000010, 1'b1, 1'b0);
        addVec(6, 1'b1, 1'b1, rPix(100), 1'b0, 1'b1, 1'b1, rPix(100), 1'b0, 1'b1, 1);
        // Group 7: two rows in one frame, second row of two pixels.
        addSame(7, 1'b1, 24'h000000, 1'b1, 1'b0);
        addPix(7, 0, 1, 1'b0, 0);
        addPix(7, 4, 4, 1'b0, 0);
        addPix(7, 8, 8, 1'b0, 0);
        addPix(7, 12, 11, 1'b0, 0);
        addPix(7, 16, 17, 1'b0, 0);
        addPix(7, 20, 19, 1'b1, 1);

        reset = 1'b1;
        enable = 1'b1;
        sink_valid = 1'b0;
        sink_data = '0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
        #3;
        checks += 4;
        if (source_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstValid: got %b want 0", source_valid); end
        if (source_data !== 24'h0) begin errors++; $display("[TB] FAIL rstData: got %h want 000000", source_data); end
        if (frame_count !== 16'h0) begin errors++; $display("[TB] FAIL rstFrameCount: got %0d want 0", frame_count); end
        if (sink_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstSinkReady: got %b want 0", sink_ready); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (sink_ready !== 1'b1) begin errors++; $display("[TB] FAIL idleSinkReady: got %b want 1", sink_ready); end

        $display("[TB] directed tables");
        runGroup(1, 0, 0, "videoFrame");
        runGroup(2, 0, 0, "nonVideo");
        runGroup(3, 0, 0, "disabled");
        runGroup(1, 1, 40, "backpressure");
        runGroup(4, 0, 0, "shortRow");
        runGroup(5, 2, 20, "singlePixel");
        runGroup(6, 2, 20, "sopInVideo");
        runGroup(7, 1, 30, "twoRows");

        $display("[TB] reset in the middle of a row");
        readyMode = 0;
        pushTx(24'h000000, 1'b1, 1'b0, 1'b1);
        pushTx(rPix(0), 1'b0, 1'b0, 1'b1);
        pushTx(rPix(4), 1'b0, 1'b0, 1'b1);
        markRows();
        applyStimulus(0);
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (source_valid !== 1'b0) begin errors++; $display("[TB] FAIL midRstValid: got %b want 0", source_valid); end
        if (frame_count !== 16'h0) begin errors++; $display("[TB] FAIL midRstFrameCount: got %0d want 0", frame_count); end
        if (sink_ready !== 1'b0) begin errors++; $display("[TB] FAIL midRstSinkReady: got %b want 0", sink_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        txQ.delete();
        expQ.delete();
        rxQ.delete();
        expFc = '0;
        runGroup(1, 0, 0, "afterReset");

        $display("[TB] randomized packets");
        for (int it = 0; it < 6; it++) begin
            for (int p = 0; p < 8; p++) genPacket();
            readyMode = 2;
            markRows();
            applyStimulus(30);
            waitDrain();
            checkOutput($sformatf("random%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_hsmooth.md
Name: stream_hsmooth

Overview:
Avalon-ST video stage placed directly upstream of the colour-detection/bounding-box processor.
- Applies a 3-tap horizontal [1 2 1]/4 smoothing to each RGB channel of video packets.
- Purpose: suppress single-pixel sensor noise before colour thresholding.
- Passes packet headers (sop word) and non-video packets through unchanged.
- Uses the same 24-bit RGB + sop/eop + valid/ready stream format on both sides.

Parameters:
- IMAGE_W, 640: pixels per row; must be >= 2.
- COUNT_W, 16: width of the filtered-frame counter.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: filter enable; sampled on each accepted sop beat.
- sink_data, in, 24: {R,G,B} pixel, or header word on sop.
- sink_valid, in, 1: input beat valid.
- sink_ready, out, 1: input beat accepted when sink_valid & sink_ready.
- sink_sop, in, 1: start of packet.
- sink_eop, in, 1: end of packet.
- source_data, out, 24: output pixel or header word.
- source_valid, out, 1: output beat valid.
- source_ready, in, 1: downstream ready.
- source_sop, out, 1: start of packet.
- source_eop, out, 1: end of packet.
- frame_count, out, COUNT_W: number of filtered video frames completed; wraps at 2^COUNT_W.

Behaviour:
- Reset (async, immediate):
  - source_valid=0, source_data/sop/eop=0, frame_count=0.
  - state=HDR, x=0, holding registers cleared.
  - Reset mid-packet discards all partial state; sink_ready is 0 while reset is asserted.
- Output register: single entry. It loads when (~source_valid | source_ready). Data, sop and eop never change while source_valid & ~source_ready.
- sink_ready = (~source_valid | source_ready) & (state != FLUSH).
- State HDR:
  - Accepted beat is copied to the output unchanged, 1-cycle latency.
  - If sop: video = (sink_data[3:0]==0) & enable. Next state is VID if video, else PASS.
  - Non-sop beat in HDR: passed through unchanged, stay in HDR.
  - sop beat that also has eop: passed through, stay in HDR.
- State PASS: every beat is copied unchanged; on an accepted eop beat go to HDR.
- State VID (holding registers prev, cur; column counter x):
  - Accepted pixel p with x==0: prev=cur=p, no output, x=1.
  - Accepted pixel p with x>0: output filt(prev, cur, p), which is the result for column x-1; then prev=cur, cur=p, x=x+1.
  - If that p is column IMAGE_W-1 or carries eop: go to FLUSH, latching last_eop=sink_eop.
- State FLUSH:
  - sink_ready=0. When the output register is free, emit filt(prev, cur, cur) (right-edge replicate) with source_eop=last_eop.
  - Then: if last_eop, go to HDR and increment frame_count; else go to VID with x=0.
- Filter: per channel out = (a + 2b + c + 2) >> 2, computed with a 10-bit intermediate. Maximum (1020+2)>>2 = 255, so no saturation is needed.
- Pixel latency:
  - Output for column k appears 1 cycle after column k+1 is accepted.
  - The last column appears 1 cycle after FLUSH is entered with the output register free.
- Boundaries:
  - Left edge replicates the pixel itself as its left neighbour.
  - eop before IMAGE_W pixels terminates the row and frame normally.
  - eop arriving on a pixel at x==0 produces a single output filt(p, p, p) = p in FLUSH.
  - sop arriving in VID or PASS is treated as a new header: partial row dropped, no flush, frame_count unchanged.
- Output beat counts:
  - Video packets: exactly one output per input pixel.
  - Bypassed packets: byte-identical to the input.

Decomposition:
- Package stream_hsmooth_pkg holds:
  - state enum {HDR, PASS, VID, FLUSH};
  - PIX_W=24, CH_W=8;
  - VIDEO_PKT_ID=4'h0.
- One sub-module, hsmooth_tap3: combinational 3-tap per-channel filter. It takes three 24-bit pixels and returns 24 bits; it is instantiated once and muxed between the VID and FLUSH operand sets.

Test Plan:
1. IMAGE_W=4, enable=1, sop header 24'h000000, then R channel 0,4,8,12 (G=B=0) with eop on the last beat -> header unchanged, then R outputs 1,4,8,11; eop on the 4th pixel; frame_count 0->1.
2. Header with blue[3:0]=4'hF followed by 3 beats 24'hABCDEF, 24'h123456, 24'h00FF00 (eop) -> all 4 beats identical at the output; frame_count unchanged.
3. enable=0 at sop, video frame as in test 1 -> pixels output unchanged (0,4,8,12); frame_count unchanged.
4. Test 1 stream with source_ready toggling 1,0,0,1,... and sink_valid gaps -> same output sequence, no drop or duplicate; sink_ready=0 in every FLUSH cycle; output held stable while stalled.
5. IMAGE_W=4, pixels R=40,80,120 with eop on the third -> outputs 50,80,110 with eop on 110; state returns to HDR; frame_count increments.
6. reset asserted after 2 pixels of a row -> source_valid=0 and frame_count=0 in the same cycle (async); after release, test 1 stimulus yields exactly the test 1 output.
